// File: rtl/el2_exu_alu_pipe_ctl.sv
// ---------------------------------------------------------------------------
// el2_exu_alu_pipe_ctl
//
// Pipelined integer ALU and branch resolver for the EXU.
//
// An operation is accepted over a valid/ready handshake. Its result, the
// branch outcome, the mispredict flag, the redirect PC and the updated
// direction counter are all computed at issue time. They then travel through
// PIPE register stages, so an unstalled op appears at the output exactly PIPE
// cycles after it is accepted. The whole pipe freezes while the output is
// valid and not accepted. Bubbles are not collapsed.
//
// A mispredicting op raises flush_upper_out on its output-handshake cycle.
// On that same cycle it kills every younger op, including the op accepted
// that cycle. flush_lower_r kills every in-flight op and suppresses
// flush_upper_out.
//
// Parameters
//   XLEN    operand/result width (power of 2, >= 16)
//   PIPE    number of result stages, 1..4 (issue-to-output latency)
//   IMM_W   branch/jal offset width, holds offset[IMM_W:1]; must be < XLEN-1
//   HIST_W  direction counter width, 1..4
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   flush_lower_r                 kill all in-flight ops
//   flush_upper_x                 kill the op offered this cycle
//   in_valid / in_ready           input handshake
//   op, a_in, b_in                opcode and operands
//   pc_in, pc4_in                 PC[XLEN-1:1]; link size select (+4 / +2)
//   imm_in                        offset[IMM_W:1] for branches and JAL
//   pred_t_in, pred_tgt_in        predicted direction / target[XLEN-1:1]
//   hist_in                       direction counter from the predictor
//   out_valid / out_ready         output handshake
//   result_out                    ALU result or link address
//   flush_upper_out               one-cycle redirect on a mispredict handshake
//   flush_path_out                redirect PC[XLEN-1:1]
//   misp_out, ataken_out          mispredict / actual taken
//   hist_out                      updated direction counter
//
// Configuration
//   EL2_ALU_ZBB_EN  enables ops 20..28: ANDN ORN XNOR CLZ CTZ CPOP MIN MAX
//                   MINU. When the macro is undefined, these ops act as NOP.
// ---------------------------------------------------------------------------
module el2_exu_alu_pipe_ctl #(
    parameter int XLEN   = 32,
    parameter int PIPE   = 2,
    parameter int IMM_W  = 20,
    parameter int HIST_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_lower_r,
    input  logic              flush_upper_x,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    input  logic [XLEN-2:0]   pc_in,
    input  logic              pc4_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              pred_t_in,
    input  logic [XLEN-2:0]   pred_tgt_in,
    input  logic [HIST_W-1:0] hist_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result_out,
    output logic              flush_upper_out,
    output logic [XLEN-2:0]   flush_path_out,
    output logic              misp_out,
    output logic              ataken_out,
    output logic [HIST_W-1:0] hist_out
);

    localparam int SH_W = $clog2(XLEN);
    localparam int PC_W = XLEN - 1;

    localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(1);
    localparam logic [PC_W-1:0]   PC_TWO   = PC_W'(2);
    localparam logic [HIST_W-1:0] HIST_ONE = HIST_W'(1);
    localparam logic [HIST_W-1:0] HIST_MAX = {HIST_W{1'b1}};

    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_PASSB = 5'd11;
    localparam logic [4:0] OP_BEQ   = 5'd12;
    localparam logic [4:0] OP_BNE   = 5'd13;
    localparam logic [4:0] OP_BLT   = 5'd14;
    localparam logic [4:0] OP_BGE   = 5'd15;
    localparam logic [4:0] OP_BLTU  = 5'd16;
    localparam logic [4:0] OP_BGEU  = 5'd17;
    localparam logic [4:0] OP_JAL   = 5'd18;
    localparam logic [4:0] OP_JALR  = 5'd19;
`ifdef EL2_ALU_ZBB_EN
    localparam logic [4:0] OP_ANDN  = 5'd20;
    localparam logic [4:0] OP_ORN   = 5'd21;
    localparam logic [4:0] OP_XNOR  = 5'd22;
    localparam logic [4:0] OP_CLZ   = 5'd23;
    localparam logic [4:0] OP_CTZ   = 5'd24;
    localparam logic [4:0] OP_CPOP  = 5'd25;
    localparam logic [4:0] OP_MIN   = 5'd26;
    localparam logic [4:0] OP_MAX   = 5'd27;
    localparam logic [4:0] OP_MINU  = 5'd28;
`endif

    // Everything an op needs at the output, computed once at issue.
    typedef struct packed {
        logic              misp;
        logic              ataken;
        logic [HIST_W-1:0] hist;
        logic [PC_W-1:0]   fpath;
        logic [XLEN-1:0]   res;
    } stage_t;

    // Saturating increment of the direction counter.
    function automatic logic [HIST_W-1:0] f_hist_inc(input logic [HIST_W-1:0] h);
        logic [HIST_W-1:0] r;
        if (h == HIST_MAX) begin
            r = h;
        end else begin
            r = h + HIST_ONE;
        end
        return r;
    endfunction

    // Saturating decrement of the direction counter.
    function automatic logic [HIST_W-1:0] f_hist_dec(input logic [HIST_W-1:0] h);
        logic [HIST_W-1:0] r;
        if (h == {HIST_W{1'b0}}) begin
            r = h;
        end else begin
            r = h - HIST_ONE;
        end
        return r;
    endfunction

`ifdef EL2_ALU_ZBB_EN
    localparam logic [XLEN-1:0] X_ONE = XLEN'(1);

    // Leading zero count; an all-zero input yields XLEN.
    function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] cnt;
        logic            hit;
        cnt = {XLEN{1'b0}};
        hit = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                cnt = cnt + X_ONE;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Trailing zero count; an all-zero input yields XLEN.
    function automatic logic [XLEN-1:0] f_ctz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] cnt;
        logic            hit;
        cnt = {XLEN{1'b0}};
        hit = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                cnt = cnt + X_ONE;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Population count.
    function automatic logic [XLEN-1:0] f_cpop(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] cnt;
        cnt = {XLEN{1'b0}};
        for (int i = 0; i < XLEN; i++) begin
            cnt = cnt + {{(XLEN-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction
`endif

    // Shared arithmetic for ALU ops and branch resolution.
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] diff_s;
    logic            eq_s;
    logic            lt_s;
    logic            ltu_s;
    logic [PC_W-1:0] imm_sext_s;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] br_tgt_s;
    logic [PC_W-1:0] jalr_tgt_s;

    assign sum_s      = a_in + b_in;
    assign diff_s     = a_in - b_in;
    assign eq_s       = (a_in == b_in);
    assign lt_s       = ($signed(a_in) < $signed(b_in));
    assign ltu_s      = (a_in < b_in);
    assign imm_sext_s = {{(PC_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};
    // PC arithmetic is in halfword units, so it wraps modulo 2^(XLEN-1).
    assign pc_next_s  = pc_in + (pc4_in ? PC_TWO : PC_ONE);
    assign br_tgt_s   = pc_in + imm_sext_s;
    assign jalr_tgt_s = sum_s[XLEN-1:1];

    logic [XLEN-1:0] res_s;
    logic            is_br_s;
    logic            is_jmp_s;
    logic            taken_s;
    logic [PC_W-1:0] tgt_s;
    stage_t          new_stg_s;

    // Opcode decode: ALU result, branch condition and control-flow target.
    always_comb begin
        res_s    = {XLEN{1'b0}};
        is_br_s  = 1'b0;
        is_jmp_s = 1'b0;
        taken_s  = 1'b0;
        tgt_s    = {PC_W{1'b0}};
        case (op)
            OP_ADD:   res_s = sum_s;
            OP_SUB:   res_s = diff_s;
            OP_AND:   res_s = a_in & b_in;
            OP_OR:    res_s = a_in | b_in;
            OP_XOR:   res_s = a_in ^ b_in;
            OP_SLL:   res_s = a_in << b_in[SH_W-1:0];
            OP_SRL:   res_s = a_in >> b_in[SH_W-1:0];
            OP_SRA:   res_s = $unsigned($signed(a_in) >>> b_in[SH_W-1:0]);
            OP_SLT:   res_s = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:  res_s = {{(XLEN-1){1'b0}}, ltu_s};
            OP_PASSB: res_s = b_in;
            OP_BEQ: begin
                is_br_s = 1'b1;
                taken_s = eq_s;
                tgt_s   = br_tgt_s;
            end
            OP_BNE: begin
                is_br_s = 1'b1;
                taken_s = ~eq_s;
                tgt_s   = br_tgt_s;
            end
            OP_BLT: begin
                is_br_s = 1'b1;
                taken_s = lt_s;
                tgt_s   = br_tgt_s;
            end
            OP_BGE: begin
                is_br_s = 1'b1;
                taken_s = ~lt_s;
                tgt_s   = br_tgt_s;
            end
            OP_BLTU: begin
                is_br_s = 1'b1;
                taken_s = ltu_s;
                tgt_s   = br_tgt_s;
            end
            OP_BGEU: begin
                is_br_s = 1'b1;
                taken_s = ~ltu_s;
                tgt_s   = br_tgt_s;
            end
            OP_JAL: begin
                is_jmp_s = 1'b1;
                taken_s  = 1'b1;
                tgt_s    = br_tgt_s;
                res_s    = {pc_next_s, 1'b0};
            end
            OP_JALR: begin
                is_jmp_s = 1'b1;
                taken_s  = 1'b1;
                tgt_s    = jalr_tgt_s;
                res_s    = {pc_next_s, 1'b0};
            end
`ifdef EL2_ALU_ZBB_EN
            OP_ANDN:  res_s = a_in & ~b_in;
            OP_ORN:   res_s = a_in | ~b_in;
            OP_XNOR:  res_s = ~(a_in ^ b_in);
            OP_CLZ:   res_s = f_clz(a_in);
            OP_CTZ:   res_s = f_ctz(a_in);
            OP_CPOP:  res_s = f_cpop(a_in);
            OP_MIN:   res_s = lt_s  ? a_in : b_in;
            OP_MAX:   res_s = lt_s  ? b_in : a_in;
            OP_MINU:  res_s = ltu_s ? a_in : b_in;
`endif
            default:  res_s = {XLEN{1'b0}};
        endcase
    end

    // Outcome of the op offered this cycle: mispredict, redirect and counter.
    always_comb begin
        new_stg_s.res    = res_s;
        new_stg_s.ataken = taken_s;
        new_stg_s.misp   = 1'b0;
        new_stg_s.fpath  = {PC_W{1'b0}};
        new_stg_s.hist   = hist_in;
        if (is_br_s) begin
            new_stg_s.misp  = (pred_t_in != taken_s);
            new_stg_s.fpath = taken_s ? tgt_s : pc_next_s;
            new_stg_s.hist  = taken_s ? f_hist_inc(hist_in) : f_hist_dec(hist_in);
        end else if (is_jmp_s) begin
            new_stg_s.misp  = ~pred_t_in | (pred_tgt_in != tgt_s);
            new_stg_s.fpath = tgt_s;
        end else begin
            new_stg_s.misp  = 1'b0;
        end
    end

    // Pipe state: per-stage valid bits and payload; stage PIPE-1 is the output.
    logic [PIPE-1:0] vld_q;
    logic [PIPE-1:0] vld_d;
    stage_t          stg_q [PIPE];
    stage_t          stg_d [PIPE];

    logic adv_s;
    logic accept_s;
    logic self_flush_s;
    logic kill_s;

    assign adv_s        = ~vld_q[PIPE-1] | out_ready;
    assign in_ready     = adv_s;
    // A kill from flush_upper_x still completes the handshake.
    assign accept_s     = in_valid & adv_s & ~flush_upper_x;
    assign self_flush_s = vld_q[PIPE-1] & out_ready & stg_q[PIPE-1].misp & ~flush_lower_r;
    // Either flush leaves no surviving op, since everything behind the output
    // stage is younger than the mispredicting op.
    assign kill_s       = flush_lower_r | self_flush_s;

    // Next-state for valids (flush > advance > hold) and payload loads.
    always_comb begin
        vld_d = vld_q;
        stg_d = stg_q;
        if (kill_s) begin
            vld_d = {PIPE{1'b0}};
        end else if (adv_s) begin
            vld_d[0] = accept_s;
            for (int i = 1; i < PIPE; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end else begin
            vld_d = vld_q;
        end
        // Payload loads only for a surviving valid op, so outputs hold across
        // bubbles and stalls.
        if (adv_s && !kill_s) begin
            if (accept_s) begin
                stg_d[0] = new_stg_s;
            end else begin
                stg_d[0] = stg_q[0];
            end
            for (int i = 1; i < PIPE; i++) begin
                if (vld_q[i-1]) begin
                    stg_d[i] = stg_q[i-1];
                end else begin
                    stg_d[i] = stg_q[i];
                end
            end
        end else begin
            stg_d = stg_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= {PIPE{1'b0}};
            for (int i = 0; i < PIPE; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            stg_q <= stg_d;
        end
    end

    assign out_valid       = vld_q[PIPE-1];
    assign result_out      = stg_q[PIPE-1].res;
    assign flush_path_out  = stg_q[PIPE-1].fpath;
    assign misp_out        = stg_q[PIPE-1].misp;
    assign ataken_out      = stg_q[PIPE-1].ataken;
    assign hist_out        = stg_q[PIPE-1].hist;
    assign flush_upper_out = self_flush_s;

endmodule

// File: tb/tb_el2_exu_alu_pipe_ctl.sv
// Testbench for el2_exu_alu_pipe_ctl.
//
// A reference model predicts each accepted op's outputs from the op's
// semantics using byte-address arithmetic. A queue tracks the ops in flight.
// Each queue entry records how many pipe advances the op has seen; the op is
// at the output once that count reaches PIPE. Directed literal checks pin
// the model at the documented scenarios.
module tb_el2_exu_alu_pipe_ctl;
    localparam int XLEN   = 32;
    localparam int PIPE   = 2;
    localparam int IMM_W  = 20;
    localparam int HIST_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_lower_r;
    logic              flush_upper_x;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op;
    logic [XLEN-1:0]   a_in;
    logic [XLEN-1:0]   b_in;
    logic [XLEN-2:0]   pc_in;
    logic              pc4_in;
    logic [IMM_W-1:0]  imm_in;
    logic              pred_t_in;
    logic [XLEN-2:0]   pred_tgt_in;
    logic [HIST_W-1:0] hist_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result_out;
    logic              flush_upper_out;
    logic [XLEN-2:0]   flush_path_out;
    logic              misp_out;
    logic              ataken_out;
    logic [HIST_W-1:0] hist_out;

    el2_exu_alu_pipe_ctl #(.XLEN(XLEN), .PIPE(PIPE), .IMM_W(IMM_W), .HIST_W(HIST_W)) dut (
        .clk(clk), .rst(rst), .flush_lower_r(flush_lower_r), .flush_upper_x(flush_upper_x),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a_in(a_in), .b_in(b_in),
        .pc_in(pc_in), .pc4_in(pc4_in), .imm_in(imm_in), .pred_t_in(pred_t_in),
        .pred_tgt_in(pred_tgt_in), .hist_in(hist_in), .out_valid(out_valid),
        .out_ready(out_ready), .result_out(result_out), .flush_upper_out(flush_upper_out),
        .flush_path_out(flush_path_out), .misp_out(misp_out), .ataken_out(ataken_out),
        .hist_out(hist_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        misp;
        logic        ataken;
        logic [1:0]  hist;
        logic [30:0] fpath;
        logic        isctl;
        int          age;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected outputs of one op, computed on byte addresses.
    function automatic exp_t calc(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [30:0] pc, input logic p4, input logic [19:0] im,
                                  input logic pt, input logic [30:0] ptg, input logic [1:0] h);
        exp_t        e;
        logic [31:0] pcb;
        logic [31:0] link;
        logic [31:0] tgtb;
        int          offb;
        int          sh;
        int          n;
        bit          isb;
        bit          isj;
        bit          tk;
        pcb  = {pc, 1'b0};
        link = pcb + (p4 ? 32'd4 : 32'd2);
        offb = int'($signed({im, 1'b0}));
        tgtb = pcb + 32'(offb);
        sh   = int'(b[4:0]);
        e.res = 32'd0; e.misp = 1'b0; e.ataken = 1'b0; e.hist = h; e.fpath = 31'd0;
        e.age = 1; isb = 0; isj = 0; tk = 0;
        case (o)
            5'd1:  e.res = a + b;
            5'd2:  e.res = a - b;
            5'd3:  e.res = a & b;
            5'd4:  e.res = a | b;
            5'd5:  e.res = a ^ b;
            5'd6:  e.res = a << sh;
            5'd7:  e.res = a >> sh;
            5'd8:  e.res = 32'($signed(a) >>> sh);
            5'd9:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: e.res = (a < b) ? 32'd1 : 32'd0;
            5'd11: e.res = b;
            5'd12: begin isb = 1; tk = (a == b); end
            5'd13: begin isb = 1; tk = (a != b); end
            5'd14: begin isb = 1; tk = ($signed(a) < $signed(b)); end
            5'd15: begin isb = 1; tk = ($signed(a) >= $signed(b)); end
            5'd16: begin isb = 1; tk = (a < b); end
            5'd17: begin isb = 1; tk = (a >= b); end
            5'd18: begin isj = 1; tk = 1; e.res = link; end
            5'd19: begin isj = 1; tk = 1; e.res = link; tgtb = (a + b) & ~32'd1; end
`ifdef EL2_ALU_ZBB_EN
            5'd20: e.res = a & ~b;
            5'd21: e.res = a | ~b;
            5'd22: e.res = ~(a ^ b);
            5'd23: begin n = 0; while (n < 32 && !a[31-n]) n++; e.res = 32'(n); end
            5'd24: begin n = 0; while (n < 32 && !a[n]) n++; e.res = 32'(n); end
            5'd25: e.res = 32'($countones(a));
            5'd26: e.res = ($signed(a) < $signed(b)) ? a : b;
            5'd27: e.res = ($signed(a) < $signed(b)) ? b : a;
            5'd28: e.res = (a < b) ? a : b;
`endif
            default: e.res = 32'd0;
        endcase
        if (isb) begin
            e.ataken = tk;
            e.misp   = (pt != tk);
            e.hist   = tk ? ((h == 2'b11) ? h : h + 2'd1) : ((h == 2'b00) ? h : h - 2'd1);
        end
        if (isj) begin
            e.ataken = 1'b1;
            e.misp   = !pt || (ptg != tgtb[31:1]);
        end
        e.fpath = tk ? tgtb[31:1] : link[31:1];
        e.isctl = isb || isj;
        return e;
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit   mov;
        bit   self_fl;
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            mov = (q.size() > 0) && (q[0].age == PIPE);
            chk("out_valid", out_valid, mov);
            chk("in_ready", in_ready, !mov || out_ready);
            chk("flush_upper_out", flush_upper_out,
                mov && out_ready && (q.size() > 0 && q[0].misp) && !flush_lower_r);
            if (mov) begin
                chk("result_out", result_out, q[0].res);
                chk("misp_out", misp_out, q[0].misp);
                chk("ataken_out", ataken_out, q[0].ataken);
                chk("hist_out", hist_out, q[0].hist);
                if (q[0].isctl) chk("flush_path_out", flush_path_out, q[0].fpath);
            end
            if (flush_lower_r) begin
                q.delete();
            end else if (!mov || out_ready) begin
                self_fl = 0;
                if (mov) begin
                    self_fl = q[0].misp;
                    void'(q.pop_front());
                end
                if (self_fl) begin
                    q.delete();
                end else begin
                    for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
                    if (in_valid && !flush_upper_x) begin
                        e = calc(op, a_in, b_in, pc_in, pc4_in, imm_in, pred_t_in, pred_tgt_in, hist_in);
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [30:0] pc, input logic p4, input logic [19:0] im,
                        input logic pt, input logic [30:0] ptg, input logic [1:0] h, input logic fux);
        int n;
        op = o; a_in = a; b_in = b; pc_in = pc; pc4_in = p4; imm_in = im;
        pred_t_in = pt; pred_tgt_in = ptg; hist_in = h; flush_upper_x = fux; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush_upper_x = 1'b0;
    endtask

    task automatic alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        send(o, a, b, 31'h40, 1'b1, 20'h8, 1'b0, 31'h0, 2'b01, 1'b0);
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, out_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush_lower_r = 1'b0; flush_upper_x = 1'b0; in_valid = 1'b0; op = 5'd0;
        a_in = '0; b_in = '0; pc_in = '0; pc4_in = 1'b0; imm_in = '0; pred_t_in = 1'b0;
        pred_tgt_in = '0; hist_in = '0; out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_flush_upper", flush_upper_out, 1'b0);
        chk("rst_flush_path", flush_path_out, 31'd0);
        chk("rst_misp", misp_out, 1'b0);
        chk("rst_ataken", ataken_out, 1'b0);
        chk("rst_hist", hist_out, 2'b00);
        idle(1);

        // 1: ADD wraps to 0, latency PIPE
        alu(5'd1, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("t1_lat1", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_lat2", out_valid, 1'b1);
        chk("t1_res", result_out, 32'd0);
        chk("t1_noflush", flush_upper_out, 1'b0);
        idle(3);

        // 2: BLT mispredict, self-flush kills the following ADD
        send(5'd14, 32'hFFFF_FFFF, 32'd0, 31'h100, 1'b1, 20'h10, 1'b0, 31'h0, 2'b01, 1'b0);
        alu(5'd1, 32'd5, 32'd6);
        @(negedge clk);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_flush", flush_upper_out, 1'b1);
        chk("t2_misp", misp_out, 1'b1);
        chk("t2_ataken", ataken_out, 1'b1);
        chk("t2_hist", hist_out, 2'b10);
        chk("t2_path", flush_path_out, 31'h110);
        @(negedge clk);
        chk("t2_flush_1cyc", flush_upper_out, 1'b0);
        repeat (3) @(negedge clk);
        chk("t2_add_gone", out_valid, 1'b0);
        idle(1);

        // 3: JALR predicted correctly
        send(5'd19, 32'h1000, 32'd5, 31'h200, 1'b1, 20'h0, 1'b1, 31'h802, 2'b01, 1'b0);
        wait_out("t3_seen");
        chk("t3_res", result_out, 32'h404);
        chk("t3_path", flush_path_out, 31'h802);
        chk("t3_misp", misp_out, 1'b0);
        chk("t3_ataken", ataken_out, 1'b1);
        chk("t3_hist", hist_out, 2'b01);
        idle(3);

        // 4: back-pressure with 3 ops
        out_ready = 1'b0;
        fork
            begin
                alu(5'd1, 32'd1, 32'd2);
                alu(5'd2, 32'd10, 32'd3);
                alu(5'd5, 32'hF0F0, 32'h0FF0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("t4_in_ready_low", in_ready, 1'b0);
                chk("t4_hold_valid", out_valid, 1'b1);
                chk("t4_hold_res", result_out, 32'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);

        // 5: flush_lower_r with a mispredict at the output
        out_ready = 1'b0;
        send(5'd13, 32'd1, 32'd2, 31'h300, 1'b0, 20'hFFFFC, 1'b0, 31'h0, 2'b10, 1'b0);
        alu(5'd1, 32'd7, 32'd8);
        @(negedge clk);
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_misp", misp_out, 1'b1);
        chk("t5_path", flush_path_out, 31'h2FC);
        @(posedge clk);
        #1;
        flush_lower_r = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_no_upper", flush_upper_out, 1'b0);
        @(posedge clk);
        #1;
        flush_lower_r = 1'b0;
        @(negedge clk);
        chk("t5_cleared", out_valid, 1'b0);
        idle(3);

        // flush_upper_x: handshake completes, op never appears
        send(5'd1, 32'd7, 32'd8, 31'h0, 1'b0, 20'h0, 1'b0, 31'h0, 2'b00, 1'b1);
        repeat (4) @(negedge clk);
        chk("fux_dropped", out_valid, 1'b0);
        idle(1);

        // 6: optional bit-manipulation ops
        alu(5'd23, 32'd0, 32'd0);
        wait_out("t6_clz_seen");
`ifdef EL2_ALU_ZBB_EN
        chk("t6_clz", result_out, 32'd32);
`else
        chk("t6_clz", result_out, 32'd0);
`endif
        idle(2);
        alu(5'd25, 32'hF0F0, 32'd0);
        wait_out("t6_cpop_seen");
`ifdef EL2_ALU_ZBB_EN
        chk("t6_cpop", result_out, 32'd8);
`else
        chk("t6_cpop", result_out, 32'd0);
`endif
        idle(2);

        // ALU op stream under intermittent back-pressure
        fork
            begin
                for (int o = 0; o < 32; o++) begin
                    if (o < 12 || o > 19) begin
                        alu(5'(o), 32'h8000_00F3 + 32'(o), 32'h0000_0004 + 32'(o));
                        alu(5'(o), 32'h0000_7F00, 32'hFFFF_FF1F);
                    end
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (k % 3 != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(6);

        // Branch/jump sweep with several operand pairs
        for (int o = 12; o < 20; o++) begin
            send(5'(o), 32'd5, 32'd5, 31'h7FFF_FFFE, 1'b0, 20'h3, 1'b1, 31'h1, 2'b11, 1'b0);
            idle(4);
            send(5'(o), 32'hFFFF_FFFF, 32'd1, 31'h1234, 1'b1, 20'h80000, 1'b0, 31'h0, 2'b00, 1'b0);
            idle(4);
            send(5'(o), 32'd3, 32'hFFFF_FFFE, 31'h10, 1'b0, 20'h4, 1'b1, 31'h0, 2'b01, 1'b0);
            idle(4);
        end

        repeat (6) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
